// File: rtl/arc4_pkg.sv
// Shared ARC4 types and constants used by the keystream/decrypt block and the crack controller.
package arc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEN_RD,
        LEN_WR,
        I_RD,
        J_RD,
        SWAP_I,
        SWAP_J,
        K_RD,
        OUT,
        DONE
    } state_t;

    // Printable ASCII window used to reject wrong keys early
    localparam logic [7:0] ARC4_PRINT_LO = 8'h20;
    localparam logic [7:0] ARC4_PRINT_HI = 8'h7E;

endpackage

// File: rtl/arc4_char_check.sv
// Combinational range check: ok_o is high when char_i lies within [LO, HI].
module arc4_char_check #(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7E
) (
    input  logic [7:0] char_i,
    output logic       ok_o
);

    assign ok_o = (char_i >= LO) && (char_i <= HI);

endmodule

// File: rtl/prga_drop_check.sv
// ARC4 keystream generator with RC4-drop[N] and optional printable-plaintext early abort.
// Decrypts a length-prefixed message from CT memory into PT memory using a pre-scheduled S.
module prga_drop_check
    import arc4_pkg::*;
#(
    parameter int unsigned DROP_N   = 0,
    parameter bit          CHECK_EN = 1'b1,
    parameter logic [7:0]  PRINT_LO = ARC4_PRINT_LO,
    parameter logic [7:0]  PRINT_HI = ARC4_PRINT_HI
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic       valid,
    output logic [7:0] s_addr,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    input  logic [7:0] s_rddata,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren,
    output state_t     dbg_state
);

    // Handshake: a start is taken only on a cycle where en=1 and rdy=1; rdy stays low
    // until the run finishes, and valid is only meaningful while rdy=1.

    localparam logic [9:0] DROP_LIM = DROP_N[9:0];

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [8:0] k_q, k_d;
    logic [7:0] len_q, len_d;
    logic [9:0] drop_q, drop_d;
    logic       fail_q, fail_d;
    logic       valid_q, valid_d;

    logic [7:0] i_inc;
    logic [7:0] j_sum;
    logic [7:0] ks_addr;
    logic [7:0] pt_byte;
    logic       char_ok;

    assign i_inc   = i_q + 8'd1;
    assign j_sum   = j_q + s_rddata;
    assign ks_addr = si_q + sj_q;
    assign pt_byte = s_rddata ^ ct_rddata;

    arc4_char_check #(
        .LO(PRINT_LO),
        .HI(PRINT_HI)
    ) u_char_check (
        .char_i(pt_byte),
        .ok_o  (char_ok)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        k_d       = k_q;
        len_d     = len_q;
        drop_d    = drop_q;
        fail_d    = fail_q;
        valid_d   = valid_q;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = LEN_RD;
                    valid_d = 1'b0;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    k_d     = 9'd1;
                    drop_d  = 10'd0;
                    fail_d  = 1'b0;
                end
            end
            LEN_RD: begin
                ct_addr = 8'd0;
                state_d = LEN_WR;
            end
            LEN_WR: begin
                len_d     = ct_rddata;
                pt_addr   = 8'd0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                if ((DROP_LIM != 10'd0) || (ct_rddata != 8'd0)) begin
                    state_d = I_RD;
                end else begin
                    state_d = DONE;
                end
            end
            I_RD: begin
                s_addr  = i_inc;
                i_d     = i_inc;
                state_d = J_RD;
            end
            J_RD: begin
                // The new j is needed as the read address in this same cycle
                si_d    = s_rddata;
                j_d     = j_sum;
                s_addr  = j_sum;
                state_d = SWAP_I;
            end
            SWAP_I: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = SWAP_J;
            end
            SWAP_J: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                if (drop_q < DROP_LIM) begin
                    drop_d  = drop_q + 10'd1;
                    state_d = I_RD;
                end else if (len_q == 8'd0) begin
                    // Empty message after the discard phase: nothing left to decrypt
                    state_d = DONE;
                end else begin
                    state_d = K_RD;
                end
            end
            K_RD: begin
                s_addr  = ks_addr;
                ct_addr = k_q[7:0];
                state_d = OUT;
            end
            OUT: begin
                pt_addr   = k_q[7:0];
                pt_wrdata = pt_byte;
                pt_wren   = 1'b1;
                if (CHECK_EN && !char_ok) begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end else if (k_q == {1'b0, len_q}) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 9'd1;
                    state_d = I_RD;
                end
            end
            DONE: begin
                valid_d = !fail_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            k_q     <= 9'd1;
            len_q   <= 8'd0;
            drop_q  <= 10'd0;
            fail_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
            len_q   <= len_d;
            drop_q  <= drop_d;
            fail_q  <= fail_d;
            valid_q <= valid_d;
        end
    end

    assign rdy       = (state_q == IDLE);
    assign valid     = valid_q;
    assign dbg_state = state_q;

endmodule

// File: doc/prga_drop_check.md
# prga_drop_check

Parametrised ARC4 keystream generator and decryptor with RC4-drop[N] support and an optional printable-plaintext check with early abort. It runs after the key-scheduling block has filled S. It decrypts a length-prefixed ciphertext from CT memory into PT memory. It reports through `valid` whether every plaintext byte passed the check, so parallel cracking cores can discard a wrong key as soon as one bad byte appears.

## Interface
Parameters:
- DROP_N, 0: keystream bytes generated and discarded before byte 1 is decrypted (0..1023).
- CHECK_EN, 1: 1 = abort on the first plaintext byte outside [PRINT_LO, PRINT_HI]; 0 = never abort.
- PRINT_LO, 8'h20: lowest acceptable plaintext byte.
- PRINT_HI, 8'h7E: highest acceptable plaintext byte.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  start request, sampled only while rdy=1
- rdy  out  1  1 = idle and able to accept en
- valid  out  1  result of the last run; held until the next accepted en
- s_addr / s_wrdata / s_wren  out  8/8/1  S memory port
- s_rddata  in  8  S read data
- ct_addr  out  8  CT address
- ct_rddata  in  8  CT read data
- pt_addr / pt_wrdata / pt_wren  out  8/8/1  PT memory port

## Operation
- All memories have synchronous read: data is valid the cycle after the address is presented.
- Message format: ct[0] = length L (0..255); bytes ct[1..L] are ciphertext.
- Outputs: pt[0] = L, and pt[k] = ct[k] ^ keystream byte k, for k = 1..L.
- Reset values: rdy=1, valid=0, s_wren=0, pt_wren=0, all addresses and write data 0, i=j=0, k=1, drop counter 0.
- Start: en=1 while rdy=1 → rdy=0 the next cycle, and valid clears to 0 at the same time. en while rdy=0 is ignored.
- Registers: i and j are 8-bit, wrapping mod 256; (si+sj) is truncated to 8 bits. k is 9-bit, so L=255 terminates correctly.
- States and actions:
  - IDLE: wait for en.
  - LEN_RD: ct_addr=0.
  - LEN_WR: latch L=ct_rddata; write pt[0]=L.
  - Next state from LEN_WR: I_RD if DROP_N>0 or L>0; otherwise DONE.
  - I_RD: s_addr=i+1; i←i+1.
  - J_RD: si←s_rddata; j←j+s_rddata; s_addr is the new j, computed combinationally.
  - SWAP_I: sj←s_rddata; write S[i]=s_rddata.
  - SWAP_J: write S[j]=si.
    - While drop count < DROP_N: increment the drop count and return to I_RD.
    - Otherwise: go to K_RD.
  - K_RD: s_addr=si+sj; ct_addr=k.
  - OUT: write pt[k]=s_rddata^ct_rddata.
    - If CHECK_EN and the byte is outside [PRINT_LO, PRINT_HI]: fail flag set, go to DONE. The failing byte is still written.
    - Else if k==L: go to DONE.
    - Else: k←k+1 and go to I_RD.
  - DONE: valid←!fail; go to IDLE.
- i==j: both swap writes hit the same address. S is unchanged, which is correct RC4 behaviour.
- Reset mid-run: the block returns to IDLE with reset values on the next edge; S and PT contents are left as they are.
- S must be re-initialised by the KSA before every start; this block does not restore S.

## Timing
- rdy is low for 3 + 4·DROP_N + 6·n cycles, where n = bytes processed (n=L on success; n = failing index on abort).
- pt_wren is a single-cycle pulse, once in LEN_WR and once per OUT.
- s_wren is high only in SWAP_I and SWAP_J.
- valid is updated in the cycle rdy returns to 1.

## Structure
- Shared package arc4_pkg holds:
  - state enum state_t: IDLE, LEN_RD, LEN_WR, I_RD, J_RD, SWAP_I, SWAP_J, K_RD, OUT, DONE
  - constants ARC4_PRINT_LO / ARC4_PRINT_HI, also used by the crack controller
- One sub-module: arc4_char_check, a combinational range comparator parametrised by LO/HI.
- Everything else sits in a single FSM plus datapath.

## Test plan
- Setup for the first three scenarios: S initialised with key "Key"; ct = {09, BB F3 16 E8 D9 40 AF 0A D3}; DROP_N=0 unless stated.
- "Plaintext" decrypt → pt = {09,"Plaintext"}, valid=1, rdy low 57 cycles.
- Abort: ct[1]=EA → pt[1]=01, valid=0, rdy low 9 cycles, pt[2..9] not written.
- Drop: DROP_N=3 → pt matches the software RC4-drop3 model; rdy low 69 cycles.
- L=0 → pt[0]=00, no S writes, valid=1, rdy low 3 cycles.
- Robustness:
  - en pulsed mid-run → ignored.
  - rst_n low mid-run → next cycle rdy=1, valid=0, wren=0.
  - New start afterwards completes correctly.
